// File: rtl/cache_bank_req_arb_pkg.sv
// cache_bank_req_arb_pkg: shared cache types and width helpers for the bank request arbiter.
package cache_bank_req_arb_pkg;
  typedef enum logic [1:0] {REQ_CORE = 2'd0, REQ_FILL = 2'd1, REQ_FLUSH = 2'd2} req_type_e;
  typedef enum logic [1:0] {ST_INIT, ST_DRAIN, ST_RUN} arb_state_e;
  // Line index width inside one bank; a single-line bank still needs one bit.
  function automatic int line_select_bits(int cache_size, int line_size, int num_banks);
    return ($clog2(cache_size / (line_size * num_banks)) < 1) ? 1 : $clog2(cache_size / (line_size * num_banks));
  endfunction
  function automatic int line_addr_width(int line_size);
    return 32 - $clog2(line_size);
  endfunction
endpackage

// File: rtl/cache_bank_req_arb_if.sv
// cache_bank_req_arb_if: flush/fill/core sources, pipeline output and status of one bank arbiter.
// slave = arbiter side, master = sources and downstream pipeline side.
interface cache_bank_req_arb_if
  import cache_bank_req_arb_pkg::*;
#(
  parameter int CACHE_SIZE = 16384,
  parameter int CACHE_LINE_SIZE = 64,
  parameter int NUM_BANKS = 1,
  parameter int WORD_SIZE = 4,
  parameter int CORE_TAG_WIDTH = 8
);
  localparam int LSB = line_select_bits(CACHE_SIZE, CACHE_LINE_SIZE, NUM_BANKS);
  localparam int LAW = line_addr_width(CACHE_LINE_SIZE);
  logic flush_valid;
  logic [LSB-1:0] flush_addr;
  logic core_req_valid;
  logic core_req_rw;
  logic [LAW-1:0] core_req_addr;
  logic [WORD_SIZE-1:0] core_req_byteen;
  logic [WORD_SIZE*8-1:0] core_req_data;
  logic [CORE_TAG_WIDTH-1:0] core_req_tag;
  logic core_req_ready;
  logic fill_valid;
  logic [LAW-1:0] fill_addr;
  logic [CACHE_LINE_SIZE*8-1:0] fill_data;
  logic fill_ready;
  logic out_valid;
  logic [1:0] out_type;
  logic [LAW-1:0] out_addr;
  logic out_rw;
  logic [WORD_SIZE-1:0] out_byteen;
  logic [CACHE_LINE_SIZE*8-1:0] out_data;
  logic [CORE_TAG_WIDTH-1:0] out_tag;
  logic out_ready;
  logic init_done;
  logic flush_err;
  modport slave (
    input flush_valid, flush_addr, core_req_valid, core_req_rw, core_req_addr, core_req_byteen,
    input core_req_data, core_req_tag, fill_valid, fill_addr, fill_data, out_ready,
    output core_req_ready, fill_ready, out_valid, out_type, out_addr, out_rw, out_byteen,
    output out_data, out_tag, init_done, flush_err
  );
  modport master (
    output flush_valid, flush_addr, core_req_valid, core_req_rw, core_req_addr, core_req_byteen,
    output core_req_data, core_req_tag, fill_valid, fill_addr, fill_data, out_ready,
    input core_req_ready, fill_ready, out_valid, out_type, out_addr, out_rw, out_byteen,
    input out_data, out_tag, init_done, flush_err
  );
endinterface

// File: rtl/cache_bank_req_arb_pipe_reg.sv
// cache_req_pipe_reg: valid/ready output register that holds its payload while stalled.
// Ports: clk, reset, in_valid/in_data (loaded on can_load), out_ready, can_load, out_valid/out_data.
module cache_req_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         can_load,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  assign can_load = !out_valid || out_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (can_load) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end
endmodule

// File: rtl/cache_bank_req_arb.sv
// cache_bank_req_arb: per-bank arbiter merging flush sweep, fill responses and core requests into pipeline stage 0.
// Ports: clk, reset (sync, active-high), bus (slave modport: sources, readies, out_* stream, init_done, flush_err).
module cache_bank_req_arb
  import cache_bank_req_arb_pkg::*;
#(
  parameter int CACHE_SIZE = 16384,
  parameter int CACHE_LINE_SIZE = 64,
  parameter int NUM_BANKS = 1,
  parameter int WORD_SIZE = 4,
  parameter int CORE_TAG_WIDTH = 8,
  parameter int FILL_STREAK_MAX = 4
) (
  input logic clk,
  input logic reset,
  cache_bank_req_arb_if.slave bus
);
  localparam int LAW = line_addr_width(CACHE_LINE_SIZE);
  localparam int DW = CACHE_LINE_SIZE * 8;
  localparam int SW = $clog2(FILL_STREAK_MAX + 1);
  localparam int PW = 2 + LAW + 1 + WORD_SIZE + DW + CORE_TAG_WIDTH;
  arb_state_e state;
  logic [SW-1:0] streak;
  logic init_done, flush_err, can_load, core_elig, fill_cand, grant_flush, grant_fill, grant_core;
  req_type_e p_type;
  logic [LAW-1:0] p_addr;
  logic [DW-1:0] p_data;
  logic [PW-1:0] p, q;
  assign core_elig = bus.core_req_valid && state == ST_RUN;
  // A waiting eligible core request forces a core grant once the fill streak saturates.
  assign fill_cand = bus.fill_valid && !(core_elig && streak == SW'(FILL_STREAK_MAX));
  assign grant_flush = can_load && bus.flush_valid;
  assign grant_fill = can_load && !bus.flush_valid && fill_cand;
  assign grant_core = can_load && !bus.flush_valid && !fill_cand && core_elig;
  assign bus.core_req_ready = grant_core;
  assign bus.fill_ready = grant_fill;
  always_comb begin
    p_type = grant_flush ? REQ_FLUSH : grant_fill ? REQ_FILL : REQ_CORE;
    p_addr = grant_flush ? LAW'(bus.flush_addr) : grant_fill ? bus.fill_addr : bus.core_req_addr;
    p_data = grant_flush ? '0 : grant_fill ? bus.fill_data : DW'(bus.core_req_data);
    p = {p_type, p_addr, grant_core & bus.core_req_rw, grant_core ? bus.core_req_byteen : '0,
         p_data, grant_core ? bus.core_req_tag : '0};
  end
  cache_req_pipe_reg #(.W(PW)) u_pipe (
    .clk(clk),
    .reset(reset),
    .in_valid(grant_flush || grant_fill || grant_core),
    .in_data(p),
    .out_ready(bus.out_ready),
    .can_load(can_load),
    .out_valid(bus.out_valid),
    .out_data(q)
  );
  assign {bus.out_type, bus.out_addr, bus.out_rw, bus.out_byteen, bus.out_data, bus.out_tag} = q;
  assign bus.init_done = init_done;
  assign bus.flush_err = flush_err;
  always_ff @(posedge clk) begin
    if (reset) streak <= '0;
    else if (!core_elig || grant_core) streak <= '0;
    else if (grant_fill && streak != SW'(FILL_STREAK_MAX)) streak <= streak + 1'b1;
  end
  // DRAIN exits once the last flush beat has left the register, i.e. whenever it could load again.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT;
      init_done <= 1'b0;
      flush_err <= 1'b0;
    end else begin
      flush_err <= flush_err | (bus.flush_valid & !can_load);
      init_done <= state == ST_RUN;
      state <= (state == ST_INIT && grant_flush && &bus.flush_addr) ? ST_DRAIN :
               (state == ST_DRAIN && can_load) ? ST_RUN : state;
    end
  end
endmodule

// File: tb/tb_cache_bank_req_arb.sv
// tb_cache_bank_req_arb: directed checks of flush sweep, core gating, fill fairness, backpressure, flush drop and reset.
module tb_cache_bank_req_arb;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  cache_bank_req_arb_if #(.CACHE_SIZE(1024), .CACHE_LINE_SIZE(16), .NUM_BANKS(1), .WORD_SIZE(4), .CORE_TAG_WIDTH(8)) bus ();
  cache_bank_req_arb #(
    .CACHE_SIZE(1024), .CACHE_LINE_SIZE(16), .NUM_BANKS(1), .WORD_SIZE(4), .CORE_TAG_WIDTH(8), .FILL_STREAK_MAX(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic sweep(input int n);
    for (int i = 0; i < n; i++) begin
      bus.flush_valid = 1'b1;
      bus.flush_addr = 6'(i);
      #1;
      chk("sweep_core_ready", bus.core_req_ready, 0);
      tick();
      chk("sweep_valid", bus.out_valid, 1);
      chk("sweep_type", bus.out_type, 2);
      chk("sweep_addr", bus.out_addr, i);
    end
    bus.flush_valid = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    bus.flush_valid = 1'b0;
    bus.flush_addr = '0;
    bus.core_req_valid = 1'b1;
    bus.core_req_rw = 1'b1;
    bus.core_req_addr = 28'h123;
    bus.core_req_byteen = 4'hf;
    bus.core_req_data = 32'hdeadbeef;
    bus.core_req_tag = 8'd5;
    bus.fill_valid = 1'b0;
    bus.fill_addr = 28'h456;
    bus.fill_data = 128'h0123456789abcdef_fedcba9876543210;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_init_done", bus.init_done, 0);
    chk("rst_flush_err", bus.flush_err, 0);
    chk("rst_out_type", bus.out_type, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_core_ready", bus.core_req_ready, 0);
    reset = 1'b0;
    sweep(64);
    chk("drain_init_done", bus.init_done, 0);
    chk("drain_core_ready", bus.core_req_ready, 0);
    tick();
    chk("run1_init_done", bus.init_done, 0);
    chk("run1_core_ready", bus.core_req_ready, 1);
    chk("run1_out_valid", bus.out_valid, 0);
    tick();
    chk("run2_init_done", bus.init_done, 1);
    chk("core_valid", bus.out_valid, 1);
    chk("core_type", bus.out_type, 0);
    chk("core_addr", bus.out_addr, 28'h123);
    chk("core_tag", bus.out_tag, 5);
    chk("core_rw", bus.out_rw, 1);
    chk("core_byteen", bus.out_byteen, 4'hf);
    chk("core_data", bus.out_data, 128'hdeadbeef);
    bus.fill_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("fair_fill_ready", bus.fill_ready, (i != 4 && i != 9));
      chk("fair_core_ready", bus.core_req_ready, (i == 4 || i == 9));
      tick();
      chk("fair_type", bus.out_type, (i == 4 || i == 9) ? 0 : 1);
      if (i == 0) begin
        chk("fill_addr", bus.out_addr, 28'h456);
        chk("fill_data", bus.out_data, 128'h0123456789abcdef_fedcba9876543210);
        chk("fill_tag", bus.out_tag, 0);
        chk("fill_rw", bus.out_rw, 0);
      end
    end
    bus.out_ready = 1'b0;
    bus.core_req_addr = 28'h200;
    #1;
    chk("bp_core_ready", bus.core_req_ready, 0);
    chk("bp_fill_ready", bus.fill_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_type", bus.out_type, 0);
      chk("bp_addr", bus.out_addr, 28'h123);
      chk("bp_tag", bus.out_tag, 5);
      chk("bp_core_ready_hold", bus.core_req_ready, 0);
      chk("bp_fill_ready_hold", bus.fill_ready, 0);
    end
    bus.out_ready = 1'b1;
    bus.fill_valid = 1'b0;
    bus.core_req_valid = 1'b0;
    tick();
    chk("bp_single_beat", bus.out_valid, 0);
    bus.flush_valid = 1'b1;
    bus.flush_addr = 6'd10;
    tick();
    chk("drop_type", bus.out_type, 2);
    chk("drop_addr10", bus.out_addr, 10);
    chk("drop_err_before", bus.flush_err, 0);
    bus.out_ready = 1'b0;
    bus.flush_addr = 6'd11;
    tick();
    chk("drop_err_set", bus.flush_err, 1);
    chk("drop_hold_addr", bus.out_addr, 10);
    bus.flush_valid = 1'b0;
    tick();
    chk("drop_err_sticky", bus.flush_err, 1);
    chk("drop_hold_addr2", bus.out_addr, 10);
    bus.out_ready = 1'b1;
    tick();
    chk("drop_no_line11", bus.out_valid, 0);
    chk("drop_err_sticky2", bus.flush_err, 1);
    reset = 1'b1;
    tick();
    chk("rst2_flush_err", bus.flush_err, 0);
    chk("rst2_init_done", bus.init_done, 0);
    reset = 1'b0;
    bus.core_req_valid = 1'b1;
    bus.core_req_addr = 28'h123;
    sweep(21);
    reset = 1'b1;
    tick();
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_init_done", bus.init_done, 0);
    chk("mid_rst_flush_err", bus.flush_err, 0);
    reset = 1'b0;
    sweep(64);
    tick();
    chk("re_run1_core_ready", bus.core_req_ready, 1);
    chk("re_run1_init_done", bus.init_done, 0);
    tick();
    chk("re_init_done", bus.init_done, 1);
    chk("re_flush_err", bus.flush_err, 0);
    chk("re_core_type", bus.out_type, 0);
    chk("re_core_valid", bus.out_valid, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_bank_req_arb.md
Name: cache_bank_req_arb

Overview:
Per-bank input arbiter in front of the cache bank pipeline. Merges three sources into one registered request stream: the flush sweep (line index plus valid, no backpressure, issued from reset), memory fill responses, and core requests. It owns the bank's init state: core traffic stays gated until every line has been flushed and handed downstream. Its output register is stage 0 of the tag/data pipeline.

Parameters:
CACHE_SIZE, 16384, cache size in bytes
CACHE_LINE_SIZE, 64, line size in bytes
NUM_BANKS, 1, number of banks
WORD_SIZE, 4, core word size in bytes
CORE_TAG_WIDTH, 8, core request tag width
FILL_STREAK_MAX, 4, max consecutive fill grants while a core request waits

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
flush_valid  in  1  flush beat present this cycle
flush_addr  in  LINE_SELECT_BITS  line index to flush
core_req_valid  in  1  core request valid
core_req_rw  in  1  1 = write
core_req_addr  in  LINE_ADDR_WIDTH  line address
core_req_byteen  in  WORD_SIZE  byte enables
core_req_data  in  WORD_SIZE*8  write data
core_req_tag  in  CORE_TAG_WIDTH  request tag
core_req_ready  out  1  core request accepted this cycle
fill_valid  in  1  fill response valid
fill_addr  in  LINE_ADDR_WIDTH  fill line address
fill_data  in  CACHE_LINE_SIZE*8  fill line data
fill_ready  out  1  fill accepted this cycle
out_valid  out  1  pipeline request valid
out_type  out  2  0 = core, 1 = fill, 2 = flush
out_addr  out  LINE_ADDR_WIDTH  line address; flush_addr is zero-extended
out_rw  out  1  core rw; 0 for fill and flush
out_byteen  out  WORD_SIZE  core byteen; 0 otherwise
out_data  out  CACHE_LINE_SIZE*8  fill data, or core data in bits [WORD_SIZE*8-1:0] with upper bits 0; 0 for flush
out_tag  out  CORE_TAG_WIDTH  core tag; 0 otherwise
out_ready  in  1  pipeline accepts
init_done  out  1  flush complete, core traffic enabled
flush_err  out  1  sticky: a flush beat was dropped

Behaviour:
- Reset values: out_valid = 0; all other out_* = 0; init_done = 0; flush_err = 0; streak = 0; state = INIT.
- Reset asserted mid-operation discards the held beat and returns the block to INIT.
- can_load = !out_valid || out_ready. The output register loads the granted request on can_load, giving a 1-cycle accept-to-out_valid latency.
- While out_valid && !out_ready, all out_* hold stable.
- Grant priority on each can_load cycle:
  - flush if flush_valid;
  - else fill if fill_valid && !(core_elig && streak == FILL_STREAK_MAX);
  - else core if core_elig.
- core_elig = core_req_valid && (state == RUN).
- core_req_ready and fill_ready are 1 only in the cycle their source is granted. They may depend on their own valid; no valid depends on a ready.
- Streak counter (saturating at FILL_STREAK_MAX):
  - +1 on a fill grant while core_elig;
  - cleared on a core grant, or in any cycle with !core_elig.
- Flush has no backpressure. flush_valid && !can_load drops the beat and sets flush_err, which is cleared only by reset.
- State machine:
  - INIT → DRAIN when a flush beat with flush_addr == 2^LINE_SELECT_BITS - 1 is loaded.
  - DRAIN → RUN when that beat leaves: !out_valid, or out_valid && out_ready. The exit is evaluated from the cycle after entry.
  - RUN persists until reset.
  - init_done = (state == RUN), registered.
- Fills are accepted in any state. Flush beats arriving in RUN are still arbitrated first.
- Derived widths:
  - LINE_SELECT_BITS = log2(CACHE_SIZE / (CACHE_LINE_SIZE * NUM_BANKS)), minimum 1;
  - LINE_ADDR_WIDTH = 32 - log2(CACHE_LINE_SIZE).

Decomposition:
- Shared cache package holds:
  - the req_type enum (CORE/FILL/FLUSH);
  - the arbiter state enum (INIT/DRAIN/RUN);
  - the LINE_SELECT_BITS and LINE_ADDR_WIDTH derivation macros, alongside the existing cache defines.
- One natural sub-module: cache_req_pipe_reg, the valid/ready output register with hold-on-stall (payload width parameter).

Test Plan:
1. Sweep: CACHE_SIZE=1024, LINE=16, BANKS=1 (64 lines), out_ready=1, flush addr 0..63 one per cycle → 64 type-2 beats with addr 0..63 in order; init_done rises 2 cycles after the addr-63 beat is loaded; core_req_ready = 0 throughout.
2. Gated core: core_req_valid held from reset with addr 0x123, tag 5 → core_req_ready first 1 in the first RUN cycle; next cycle out_type 0, out_addr 0x123, out_tag 5.
3. Fairness: FILL_STREAK_MAX=4, fill_valid and core_req_valid held in RUN, out_ready=1 → grant sequence F F F F C F F F F C.
4. Backpressure: core beat loaded, then out_ready=0 for 3 cycles → out_* stable, core_req_ready=0 and fill_ready=0; exactly one beat transferred when out_ready returns.
5. Flush drop: out_ready=0 while the flush beat for line 10 is held and line 11 arrives → flush_err=1 next cycle, stays 1 to reset; line 11 never appears on out.
6. Reset mid-sweep at line 20 → out_valid=0 and init_done=0 next cycle; new sweep from line 0 completes normally and flush_err stays 0.
